// File: rtl/hazard_pkg.sv
// Shared types and constants for the issue-stage hazard scoreboard.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int MAX_DEPTH  = 4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // One in-flight destination: valid flag plus the register it will write.
    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
    } sb_entry_t;

    // True when an in-flight entry will write the given source register.
    // $0 is hardwired to zero, so it can never be a true dependency.
    function automatic logic entry_matches(input sb_entry_t e,
                                           input logic [REG_ADDR_W-1:0] addr);
        return e.v && (e.rd == addr) && (addr != '0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_shift.sv
// Shift register of in-flight destination entries, entry 0 youngest.
// Every cycle the whole chain advances by one; a synchronous clear empties it.
module inflight_shift_reg
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3
)
(
    input  logic                  clk,
    input  logic                  clr,
    input  sb_entry_t             entry_in,
    output sb_entry_t [DEPTH-1:0] entries
);

    sb_entry_t [DEPTH-1:0] entries_q;
    sb_entry_t [DEPTH-1:0] entries_d;

    // Next chain contents: new entry at the young end, everything else moves one older.
    always_comb begin
        entries_d    = entries_q;
        entries_d[0] = entry_in;
        for (int k = 1; k < DEPTH; k++) begin
            entries_d[k] = entries_q[k-1];
        end
    end

    // Chain register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    assign entries = entries_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage interlock for the non-forwarding 5-stage pipeline.
// Tracks in-flight destination registers, stalls the ID instruction on a
// RAW hazard, and offers a drain handshake to quiesce the pipeline.
// Optional build macro HAZARD_STALL_CNT_EN adds a saturating stall_cycles
// counter of hazard (not drain) stall cycles.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal issue; stall only on a RAW hazard
// DRAIN | issue blocked; drain_ack once every in-flight entry has retired
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter bit RF_BYPASS = 1'b0
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    input  logic                  drain_req,
    output logic                  pc_hold,
    output logic                  if_id_hold,
    output logic                  id_ex_bubble,
    output logic                  drain_ack,
    output logic [2:0]            inflight_cnt
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    // With a write-before-read register file the WB entry's value is already
    // visible to ID, so the oldest entry drops out of the compare window.
    localparam int CMP_N = RF_BYPASS ? DEPTH - 1 : DEPTH;

    state_e                state_q;
    state_e                state_d;
    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t             new_entry;
    logic                  rs_match;
    logic                  rt_match;
    logic                  hazard;
    logic                  stall;
    logic                  issue;
    logic [2:0]            cnt;

    // Source-operand compare against the in-flight window.
    always_comb begin
        rs_match = 1'b0;
        rt_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < CMP_N) begin
                if (entry_matches(entries[k], id_rs_addr)) begin
                    rs_match = 1'b1;
                end
                if (entry_matches(entries[k], id_rt_addr)) begin
                    rt_match = 1'b1;
                end
            end
        end
        hazard = id_valid & (rs_match | (id_uses_rt & rt_match));
    end

    // Stall/issue decision and the entry recorded for the issuing instruction.
    // A stalled cycle records an invalid entry, which is the bubble entering EX.
    always_comb begin
        stall        = hazard | (state_q == DRAIN);
        issue        = id_valid & ~stall;
        new_entry.v  = issue & id_reg_write & (id_rd_addr != '0);
        new_entry.rd = id_rd_addr;
    end

    inflight_shift_reg #(
        .DEPTH (DEPTH)
    ) u_shift (
        .clk      (clk),
        .clr      (rst),
        .entry_in (new_entry),
        .entries  (entries)
    );

    // Population count over all entries, including WB even under bypass.
    always_comb begin
        cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt = cnt + 3'(entries[k].v);
        end
    end

    // Drain FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_req)  state_d = DRAIN;
            DRAIN:   if (!drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Pipeline controls; all forced inactive while reset is asserted.
    always_comb begin
        pc_hold      = stall & ~rst;
        if_id_hold   = stall & ~rst;
        id_ex_bubble = stall & ~rst;
        drain_ack    = ~rst & (state_q == DRAIN) & (cnt == 3'd0);
        inflight_cnt = cnt;
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    // Count hazard cycles only, saturating at all-ones.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (hazard && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: instance 0 is DEPTH=3 without bypass, instance 1 is
// DEPTH=3 with RF_BYPASS=1. Each scenario drives one instance while the
// other sits idle.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic       id_valid     [2];
    logic [4:0] id_rs_addr   [2];
    logic [4:0] id_rt_addr   [2];
    logic       id_uses_rt   [2];
    logic [4:0] id_rd_addr   [2];
    logic       id_reg_write [2];
    logic       drain_req    [2];
    logic       pc_hold      [2];
    logic       if_id_hold   [2];
    logic       id_ex_bubble [2];
    logic       drain_ack    [2];
    logic [2:0] inflight_cnt [2];
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles [2];
`endif

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.DEPTH(3), .RF_BYPASS(1'b0)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid[0]),
        .id_rs_addr   (id_rs_addr[0]),
        .id_rt_addr   (id_rt_addr[0]),
        .id_uses_rt   (id_uses_rt[0]),
        .id_rd_addr   (id_rd_addr[0]),
        .id_reg_write (id_reg_write[0]),
        .drain_req    (drain_req[0]),
        .pc_hold      (pc_hold[0]),
        .if_id_hold   (if_id_hold[0]),
        .id_ex_bubble (id_ex_bubble[0]),
        .drain_ack    (drain_ack[0]),
        .inflight_cnt (inflight_cnt[0])
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles[0])
`endif
    );

    hazard_scoreboard #(.DEPTH(3), .RF_BYPASS(1'b1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid[1]),
        .id_rs_addr   (id_rs_addr[1]),
        .id_rt_addr   (id_rt_addr[1]),
        .id_uses_rt   (id_uses_rt[1]),
        .id_rd_addr   (id_rd_addr[1]),
        .id_reg_write (id_reg_write[1]),
        .drain_req    (drain_req[1]),
        .pc_hold      (pc_hold[1]),
        .if_id_hold   (if_id_hold[1]),
        .id_ex_bubble (id_ex_bubble[1]),
        .drain_ack    (drain_ack[1]),
        .inflight_cnt (inflight_cnt[1])
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles[1])
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int w, input logic v, input logic [4:0] rs,
                          input logic [4:0] rt, input logic ut,
                          input logic [4:0] rd, input logic wr);
        id_valid[w]     = v;
        id_rs_addr[w]   = rs;
        id_rt_addr[w]   = rt;
        id_uses_rt[w]   = ut;
        id_rd_addr[w]   = rd;
        id_reg_write[w] = wr;
    endtask

    task automatic idle(input int w);
        set_id(w, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_id(0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1);
        idle(1);
        drain_req[0] = 1'b0;
        drain_req[1] = 1'b1;
        tick();
        tick();
        for (int w = 0; w < 2; w++) begin
            checks++;
            if ({pc_hold[w], if_id_hold[w], id_ex_bubble[w], drain_ack[w]} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %b%b%b%b want 0000", w,
                         pc_hold[w], if_id_hold[w], id_ex_bubble[w], drain_ack[w]);
            end
            checks++;
            if (inflight_cnt[w] !== 3'd0) begin
                errors++;
                $display("FAIL reset_cnt dut%0d: got %0d want 0", w, inflight_cnt[w]);
            end
        end
        rst = 1'b0;
        drain_req[1] = 1'b0;
        idle(0);
        #1;
        for (int w = 0; w < 2; w++) begin
            checks++;
            if ({pc_hold[w], drain_ack[w], inflight_cnt[w]} !== 5'b00000) begin
                errors++;
                $display("FAIL post_reset dut%0d: hold=%b ack=%b cnt=%0d want 0 0 0", w,
                         pc_hold[w], drain_ack[w], inflight_cnt[w]);
            end
        end
        tick();
    endtask

    // add $3,$1,$2 ; sub $4,$3,$5
    task automatic test_back_to_back(input int w);
        int n;
        n = (w == 1) ? 2 : 3;
        set_id(w, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1);
        #1;
        checks++;
        if (pc_hold[w] !== 1'b0 || inflight_cnt[w] !== 3'd0) begin
            errors++;
            $display("FAIL b2b_producer dut%0d: hold=%b cnt=%0d want 0 0", w, pc_hold[w], inflight_cnt[w]);
        end
        tick();
        set_id(w, 1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1);
        for (int c = 0; c <= n; c++) begin
            logic       exp_h;
            logic [2:0] exp_c;
            #1;
            exp_h = (c < n);
            exp_c = (c < n) ? 3'd1 : ((w == 1) ? 3'd1 : 3'd0);
            checks++;
            if (pc_hold[w] !== exp_h || if_id_hold[w] !== exp_h || id_ex_bubble[w] !== exp_h) begin
                errors++;
                $display("FAIL b2b_hold dut%0d cyc%0d: got %b%b%b want %b", w, c,
                         pc_hold[w], if_id_hold[w], id_ex_bubble[w], exp_h);
            end
            checks++;
            if (inflight_cnt[w] !== exp_c) begin
                errors++;
                $display("FAIL b2b_cnt dut%0d cyc%0d: got %0d want %0d", w, c, inflight_cnt[w], exp_c);
            end
            tick();
        end
        idle(w);
        #1;
        checks++;
        if (inflight_cnt[w] !== 3'd1) begin
            errors++;
            $display("FAIL b2b_sub_recorded dut%0d: got %0d want 1", w, inflight_cnt[w]);
        end
        flush(3);
        checks++;
        if (inflight_cnt[w] !== 3'd0) begin
            errors++;
            $display("FAIL b2b_retired dut%0d: got %0d want 0", w, inflight_cnt[w]);
        end
    endtask

    // add $3,$1,$2 ; or $6,$7,$8 ; and $9,$3,$3
    task automatic test_independent(input int w);
        int n;
        n = (w == 1) ? 1 : 2;
        set_id(w, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1);
        tick();
        set_id(w, 1'b1, 5'd7, 5'd8, 1'b1, 5'd6, 1'b1);
        #1;
        checks++;
        if (pc_hold[w] !== 1'b0 || inflight_cnt[w] !== 3'd1) begin
            errors++;
            $display("FAIL indep_or dut%0d: hold=%b cnt=%0d want 0 1", w, pc_hold[w], inflight_cnt[w]);
        end
        tick();
        set_id(w, 1'b1, 5'd3, 5'd3, 1'b1, 5'd9, 1'b1);
        for (int c = 0; c <= n; c++) begin
            #1;
            checks++;
            if (pc_hold[w] !== (c < n)) begin
                errors++;
                $display("FAIL indep_and_hold dut%0d cyc%0d: got %b want %b", w, c, pc_hold[w], (c < n));
            end
            tick();
        end
        idle(w);
        flush(4);
        checks++;
        if (inflight_cnt[w] !== 3'd0) begin
            errors++;
            $display("FAIL indep_retired dut%0d: got %0d want 0", w, inflight_cnt[w]);
        end
    endtask

    // add $0,$1,$2 ; sub $4,$0,$0
    task automatic test_zero_reg(input int w);
        set_id(w, 1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1);
        tick();
        set_id(w, 1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b1);
        #1;
        checks++;
        if (pc_hold[w] !== 1'b0 || inflight_cnt[w] !== 3'd0) begin
            errors++;
            $display("FAIL zero_reg dut%0d: hold=%b cnt=%0d want 0 0", w, pc_hold[w], inflight_cnt[w]);
        end
        tick();
        idle(w);
        flush(3);
    endtask

    // rt of a shift-immediate form is not a source; a real rt source is.
    task automatic test_uses_rt(input int w);
        set_id(w, 1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1);
        tick();
        set_id(w, 1'b1, 5'd1, 5'd5, 1'b0, 5'd6, 1'b1);
        #1;
        checks++;
        if (pc_hold[w] !== 1'b0) begin
            errors++;
            $display("FAIL rt_unused dut%0d: got %b want 0", w, pc_hold[w]);
        end
        tick();
        set_id(w, 1'b1, 5'd1, 5'd5, 1'b1, 5'd7, 1'b1);
        #1;
        checks++;
        if (pc_hold[w] !== 1'b1) begin
            errors++;
            $display("FAIL rt_used dut%0d: got %b want 1", w, pc_hold[w]);
        end
        idle(w);
        flush(5);
    endtask

    task automatic test_drain(input int w);
        set_id(w, 1'b1, 5'd1, 5'd2, 1'b1, 5'd10, 1'b1);
        tick();
        set_id(w, 1'b1, 5'd1, 5'd2, 1'b1, 5'd11, 1'b1);
        tick();
        set_id(w, 1'b1, 5'd1, 5'd2, 1'b1, 5'd12, 1'b1);
        drain_req[w] = 1'b1;
        #1;
        checks++;
        if (pc_hold[w] !== 1'b0 || drain_ack[w] !== 1'b0) begin
            errors++;
            $display("FAIL drain_same_cycle_issue dut%0d: hold=%b ack=%b want 0 0", w, pc_hold[w], drain_ack[w]);
        end
        tick();
        set_id(w, 1'b1, 5'd1, 5'd2, 1'b1, 5'd13, 1'b1);
        for (int i = 0; i < 4; i++) begin
            logic [2:0] exp_c;
            exp_c = 3'(3 - i);
            #1;
            checks++;
            if (pc_hold[w] !== 1'b1 || id_ex_bubble[w] !== 1'b1) begin
                errors++;
                $display("FAIL drain_hold dut%0d step%0d: got %b%b want 11", w, i, pc_hold[w], id_ex_bubble[w]);
            end
            checks++;
            if (inflight_cnt[w] !== exp_c || drain_ack[w] !== (i == 3)) begin
                errors++;
                $display("FAIL drain_progress dut%0d step%0d: cnt=%0d ack=%b want %0d %b", w, i,
                         inflight_cnt[w], drain_ack[w], exp_c, (i == 3));
            end
            tick();
        end
        drain_req[w] = 1'b0;
        #1;
        checks++;
        if (pc_hold[w] !== 1'b1 || drain_ack[w] !== 1'b1) begin
            errors++;
            $display("FAIL drain_release_cycle dut%0d: hold=%b ack=%b want 1 1", w, pc_hold[w], drain_ack[w]);
        end
        tick();
        #1;
        checks++;
        if (pc_hold[w] !== 1'b0 || drain_ack[w] !== 1'b0) begin
            errors++;
            $display("FAIL drain_resume dut%0d: hold=%b ack=%b want 0 0", w, pc_hold[w], drain_ack[w]);
        end
        tick();
        idle(w);
        #1;
        checks++;
        if (inflight_cnt[w] !== 3'd1) begin
            errors++;
            $display("FAIL drain_resume_issue dut%0d: cnt=%0d want 1", w, inflight_cnt[w]);
        end
        flush(3);
    endtask

    task automatic test_reset_mid_stall(input int w);
        set_id(w, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1);
        tick();
        set_id(w, 1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1);
        #1;
        checks++;
        if (pc_hold[w] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre dut%0d: got %b want 1", w, pc_hold[w]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({pc_hold[w], if_id_hold[w], id_ex_bubble[w], drain_ack[w]} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_forced dut%0d: got %b%b%b%b want 0000", w,
                     pc_hold[w], if_id_hold[w], id_ex_bubble[w], drain_ack[w]);
        end
        tick();
        checks++;
        if (inflight_cnt[w] !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid_cleared dut%0d: got %0d want 0", w, inflight_cnt[w]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (pc_hold[w] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_issue dut%0d: got %b want 0", w, pc_hold[w]);
        end
`ifdef HAZARD_STALL_CNT_EN
        checks++;
        if (stall_cycles[w] !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_stall_cycles dut%0d: got %0d want 0", w, stall_cycles[w]);
        end
`endif
        tick();
        idle(w);
        #1;
        checks++;
        if (inflight_cnt[w] !== 3'd1) begin
            errors++;
            $display("FAIL rst_mid_recorded dut%0d: got %0d want 1", w, inflight_cnt[w]);
        end
        flush(3);
    endtask

    initial begin
        rst = 1'b1;
        for (int w = 0; w < 2; w++) begin
            idle(w);
            drain_req[w] = 1'b0;
        end
        test_reset();
        for (int w = 0; w < 2; w++) begin
            test_back_to_back(w);
            test_independent(w);
            test_zero_reg(w);
            test_uses_rt(w);
            test_drain(w);
            test_reset_mid_stall(w);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
